// File: rtl/ai_predictive_opponent.sv
// AI paddle controller: waits a reaction delay, predicts the ball's intercept with wall folding,
// then walks the paddle toward the predicted point plus a pseudo-random aim error.
module ai_predictive_opponent #(
  parameter int unsigned CLK_HZ     = 25_175_000,
  parameter int unsigned V_VIDEO    = 480,
  parameter int unsigned PDL_HEIGHT = 96,
  parameter int unsigned SQ_W       = 16,
  parameter int unsigned AI_X       = 608,
  parameter int unsigned SPEED_0    = 300,
  parameter int unsigned SPEED_1    = 450,
  parameter int unsigned SPEED_2    = 600,
  parameter int unsigned REACT_MS_0 = 500,
  parameter int unsigned REACT_MS_1 = 300,
  parameter int unsigned REACT_MS_2 = 150,
  parameter int unsigned ERR_0      = 31,
  parameter int unsigned ERR_1      = 15,
  parameter int unsigned ERR_2      = 3,
  parameter int unsigned DEADBAND   = 2,
  parameter int unsigned MAX_ITER   = 1023
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [9:0] sq_xpos,
  input  logic [9:0] sq_ypos,
  input  logic       sq_xveldir,
  input  logic       sq_yveldir,
  input  logic [3:0] sq_xspeed,
  input  logic [3:0] sq_yspeed,
  input  logic       reset_game,
  input  logic       sq_missed,
  input  logic [1:0] difficulty,
  output logic [9:0] ai_ypos,
  output logic [9:0] target_y,
  output logic       ai_busy
);

  localparam logic [9:0]  Centre = 10'(V_VIDEO / 2 - PDL_HEIGHT / 2);
  localparam int unsigned YMax   = V_VIDEO - PDL_HEIGHT;
  localparam int unsigned BMax   = V_VIDEO - SQ_W;

  typedef enum logic [2:0] {StIdle, StReact, StPredict, StTrack, StReturn} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, presc_q, presc_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  py_q, py_d, it_q, it_d, ypos_q, ypos_d, target_q, target_d;
  logic [3:0]  vx_q, vx_d, vy_q, vy_d;
  logic [1:0]  dlat_q, dlat_d;
  logic        dy_q, dy_d, xdir_q, busy_q;
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [31:0] react_len(input logic [1:0] d);
    case (d)
      2'd0:    react_len = 32'(REACT_MS_0 * (CLK_HZ / 1000));
      2'd1:    react_len = 32'(REACT_MS_1 * (CLK_HZ / 1000));
      default: react_len = 32'(REACT_MS_2 * (CLK_HZ / 1000));
    endcase
  endfunction

  function automatic logic [31:0] tick_len(input logic [1:0] d);
    case (d)
      2'd0:    tick_len = 32'(CLK_HZ / SPEED_0);
      2'd1:    tick_len = 32'(CLK_HZ / SPEED_1);
      default: tick_len = 32'(CLK_HZ / SPEED_2);
    endcase
  endfunction

  function automatic logic [4:0] err_mask(input logic [1:0] d);
    case (d)
      2'd0:    err_mask = 5'(ERR_0);
      2'd1:    err_mask = 5'(ERR_1);
      default: err_mask = 5'(ERR_2);
    endcase
  endfunction

  logic        rise, fall, tick, done, near_centre;
  logic [31:0] prd;
  logic [10:0] sum_dn;
  logic [11:0] off, base12, tgt12;
  logic [9:0]  tgt_clamp;

  always_comb begin
    rise        = sq_xveldir & ~xdir_q;
    fall        = ~sq_xveldir & xdir_q;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    prd         = (state_q == StReturn) ? tick_len(2'd0) : tick_len(dlat_q);
    tick        = (presc_q == prd - 32'd1);
    done        = (({1'b0, px_q} + 12'(SQ_W)) >= 12'(AI_X)) || (it_q == 10'(MAX_ITER));
    sum_dn      = {1'b0, py_q} + {7'b0, vy_q};
    near_centre = ({1'b0, ypos_q} <= {1'b0, Centre} + 11'(DEADBAND)) &&
                  ({1'b0, ypos_q} + 11'(DEADBAND) >= {1'b0, Centre});
    // Signed 12-bit intercept; bit 11 set means the aim point went above the screen.
    off    = {7'b0, lfsr_q[4:0] & err_mask(dlat_q)};
    base12 = {2'b0, py_q} + 12'(SQ_W / 2) - 12'(PDL_HEIGHT / 2);
    tgt12  = lfsr_q[5] ? base12 - off : base12 + off;
    if (tgt12[11])              tgt_clamp = 10'd0;
    else if (tgt12 > 12'(YMax)) tgt_clamp = 10'(YMax);
    else                        tgt_clamp = tgt12[9:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    px_d     = px_q;
    py_d     = py_q;
    dy_d     = dy_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    it_d     = it_q;
    dlat_d   = dlat_q;
    target_d = target_q;
    ypos_d   = ypos_q;

    if (state_q == StTrack || state_q == StReturn) begin
      if (tick) begin
        presc_d = 32'd0;
        if ({1'b0, ypos_q} > {1'b0, target_q} + 11'(DEADBAND)) begin
          ypos_d = ypos_q - 10'd1;
        end else if ({1'b0, ypos_q} + 11'(DEADBAND) < {1'b0, target_q}) begin
          ypos_d = ypos_q + 10'd1;
        end
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end

    unique case (state_q)
      StIdle, StReturn: begin
        if (rise && !sq_missed) begin
          dlat_d  = difficulty;
          cnt_d   = 32'd0;
          state_d = StReact;
        end else if (state_q == StReturn && near_centre) begin
          state_d = StIdle;
        end
      end
      StReact, StPredict, StTrack: begin
        if (sq_missed || fall) begin
          target_d = Centre;
          cnt_d    = 32'd0;
          presc_d  = 32'd0;
          state_d  = StReturn;
        end else if (state_q == StTrack) begin
          if (rise) begin
            dlat_d  = difficulty;
            cnt_d   = 32'd0;
            state_d = StReact;
          end
        end else if (state_q == StReact) begin
          if (cnt_q == react_len(dlat_q) - 32'd1) begin
            px_d    = {1'b0, sq_xpos};
            py_d    = sq_ypos;
            dy_d    = sq_yveldir;
            vx_d    = (sq_xspeed == 4'd0) ? 4'd1 : sq_xspeed;
            vy_d    = sq_yspeed;
            it_d    = 10'd0;
            state_d = StPredict;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else if (done) begin
          target_d = tgt_clamp;
          presc_d  = 32'd0;
          state_d  = StTrack;
        end else begin
          px_d = px_q + {7'b0, vx_q};
          it_d = it_q + 10'd1;
          // Reflect off the bottom / top wall by mirroring the overshoot.
          if (dy_q) begin
            if (sum_dn > 11'(BMax)) begin
              py_d = 10'(11'(2 * BMax) - sum_dn);
              dy_d = 1'b0;
            end else begin
              py_d = sum_dn[9:0];
            end
          end else if (py_q < {6'b0, vy_q}) begin
            py_d = {6'b0, vy_q} - py_q;
            dy_d = 1'b1;
          end else begin
            py_d = py_q - {6'b0, vy_q};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_0) begin
    xdir_q <= sq_xveldir;
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
    if (rst || reset_game) begin
      state_q  <= StIdle;
      cnt_q    <= 32'd0;
      presc_q  <= 32'd0;
      px_q     <= 11'd0;
      py_q     <= 10'd0;
      dy_q     <= 1'b0;
      vx_q     <= 4'd0;
      vy_q     <= 4'd0;
      it_q     <= 10'd0;
      dlat_q   <= 2'd0;
      target_q <= Centre;
      ypos_q   <= Centre;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      px_q     <= px_d;
      py_q     <= py_d;
      dy_q     <= dy_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      it_q     <= it_d;
      dlat_q   <= dlat_d;
      target_q <= target_d;
      ypos_q   <= ypos_d;
      busy_q   <= (state_d == StReact) || (state_d == StPredict);
    end
  end

  assign ai_ypos  = ypos_q;
  assign target_y = target_q;
  assign ai_busy  = busy_q;

endmodule
